// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-stage PC select unit.
// Source indices double as redirect priorities: lower index wins.
package pc_pkg;

  localparam int DEFAULT_XLEN = 32;
  localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef logic [DEFAULT_XLEN-1:0] pc_t;

  typedef enum logic [1:0] {
    SRC_TRAP   = 2'd0,
    SRC_BRANCH = 2'd1,
    SRC_JUMP   = 2'd2
  } pc_src_e;

endpackage

// File: rtl/pc_redirect_arbiter.sv
// Combinational fixed-priority arbiter over NUM_SRC redirect requests.
// The lowest asserted index wins, and its packed target is forwarded.
module pc_redirect_arbiter
  import pc_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int XLEN    = DEFAULT_XLEN,
  parameter int IDXW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0]      valid_i,
  input  logic [NUM_SRC*XLEN-1:0] target_i,
  output logic                    hit_o,
  output logic [IDXW-1:0]         idx_o,
  output logic [XLEN-1:0]         target_o
);

  // Walk from the lowest priority upward so the last match is the winner.
  always_comb begin
    hit_o    = 1'b0;
    idx_o    = '0;
    target_o = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        hit_o    = 1'b1;
        idx_o    = i[IDXW-1:0];
        target_o = target_i[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/program_counter_select_unit.sv
// Registered fetch PC with prioritised redirects, stall and a pending redirect slot.
// Optional feature PC_MISALIGN_TRAP_EN: misaligned targets trap to RESET_VECTOR.
module program_counter_select_unit
  import pc_pkg::*;
#(
  parameter int               XLEN         = DEFAULT_XLEN,
  parameter int               NUM_SRC      = 3,
  parameter int               INC_BYTES    = 4,
  parameter logic [XLEN-1:0]  RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic [NUM_SRC-1:0]      redirectValid,
  input  logic [NUM_SRC*XLEN-1:0] redirectTarget,
  output logic [XLEN-1:0]         pcOut,
  output logic [XLEN-1:0]         pcIncrementOut,
  output logic                    pcValid,
  output logic                    redirectTaken,
  output logic                    redirectPending,
  output logic                    misalignedOut
);

  localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [XLEN-1:0] INC_VAL = XLEN'(INC_BYTES);

  logic            arbHit;
  logic [IDXW-1:0] arbIdx;
  logic [XLEN-1:0] arbTarget;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            taken_q, taken_d;
  logic            pendValid_q, pendValid_d;
  logic [IDXW-1:0] pendIdx_q, pendIdx_d;
  logic [XLEN-1:0] pendTarget_q, pendTarget_d;

  logic            selHit;
  logic [IDXW-1:0] selIdx;
  logic [XLEN-1:0] selTarget;

  pc_redirect_arbiter #(
    .NUM_SRC (NUM_SRC),
    .XLEN    (XLEN),
    .IDXW    (IDXW)
  ) u_arbiter (
    .valid_i  (redirectValid),
    .target_i (redirectTarget),
    .hit_o    (arbHit),
    .idx_o    (arbIdx),
    .target_o (arbTarget)
  );

  // A new request beats the pending one on equal index because it is newer.
  always_comb begin
    selHit    = 1'b0;
    selIdx    = '0;
    selTarget = '0;
    if (arbHit && (!pendValid_q || (arbIdx <= pendIdx_q))) begin
      selHit    = 1'b1;
      selIdx    = arbIdx;
      selTarget = arbTarget;
    end else if (pendValid_q) begin
      selHit    = 1'b1;
      selIdx    = pendIdx_q;
      selTarget = pendTarget_q;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misal_q, misal_d;
`endif

  always_comb begin
    pc_d         = pc_q;
    valid_d      = valid_q;
    taken_d      = 1'b0;
    pendValid_d  = pendValid_q;
    pendIdx_d    = pendIdx_q;
    pendTarget_d = pendTarget_q;
`ifdef PC_MISALIGN_TRAP_EN
    misal_d      = 1'b0;
`endif
    if (!valid_q) begin
      valid_d = 1'b1;
    end else if (stall) begin
      if (selHit) begin
        pendValid_d  = 1'b1;
        pendIdx_d    = selIdx;
        pendTarget_d = selTarget;
      end
    end else if (selHit) begin
      taken_d     = 1'b1;
      pendValid_d = 1'b0;
      pc_d        = selTarget;
`ifdef PC_MISALIGN_TRAP_EN
      if (selTarget[1:0] != 2'b00) begin
        pc_d    = RESET_VECTOR;
        misal_d = 1'b1;
      end
`endif
    end else begin
      pc_d = pc_q + INC_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q         <= RESET_VECTOR;
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      pendValid_q  <= 1'b0;
      pendIdx_q    <= '0;
      pendTarget_q <= '0;
`ifdef PC_MISALIGN_TRAP_EN
      misal_q      <= 1'b0;
`endif
    end else begin
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      taken_q      <= taken_d;
      pendValid_q  <= pendValid_d;
      pendIdx_q    <= pendIdx_d;
      pendTarget_q <= pendTarget_d;
`ifdef PC_MISALIGN_TRAP_EN
      misal_q      <= misal_d;
`endif
    end
  end

  assign pcOut           = pc_q;
  assign pcIncrementOut  = pc_q + INC_VAL;
  assign pcValid         = valid_q;
  assign redirectTaken   = taken_q;
  assign redirectPending = pendValid_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalignedOut   = misal_q;
`else
  assign misalignedOut   = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter_select_unit.sv
// Directed plus random bench for program_counter_select_unit against a rule-level model.
// Honors PC_MISALIGN_TRAP_EN so it can run against either build.
module tb_program_counter_select_unit;
  import pc_pkg::*;

  localparam int XLEN = 32;
  localparam int NSRC = 3;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic              clk;
  logic              reset;
  logic              stall;
  logic [NSRC-1:0]   redirectValid;
  logic [NSRC*XLEN-1:0] redirectTarget;
  logic [XLEN-1:0]   pcOut;
  logic [XLEN-1:0]   pcIncrementOut;
  logic              pcValid;
  logic              redirectTaken;
  logic              redirectPending;
  logic              misalignedOut;

  int checks = 0;
  int errors = 0;

  // Reference state, described by what the unit promises rather than how it is built.
  logic [31:0] mPc;
  logic        mValid, mTaken, mPend, mMis;
  int          mPendIdx;
  logic [31:0] mPendTgt;

  program_counter_select_unit dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirectValid   (redirectValid),
    .redirectTarget  (redirectTarget),
    .pcOut           (pcOut),
    .pcIncrementOut  (pcIncrementOut),
    .pcValid         (pcValid),
    .redirectTaken   (redirectTaken),
    .redirectPending (redirectPending),
    .misalignedOut   (misalignedOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic rstN, input logic st, input logic [2:0] vld,
                           input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
    logic [31:0] tg[3];
    int w;
    int selIdx;
    logic [31:0] selTgt;
    tg[0] = t0; tg[1] = t1; tg[2] = t2;
    if (!rstN) begin
      mPc = RV; mValid = 0; mTaken = 0; mPend = 0; mPendIdx = 0; mPendTgt = 0; mMis = 0;
      return;
    end
    mTaken = 0;
    mMis = 0;
    if (!mValid) begin
      mValid = 1;
      return;
    end
    w = -1;
    for (int i = 2; i >= 0; i--) if (vld[i]) w = i;
    selIdx = -1;
    selTgt = 0;
    if (w >= 0 && (!mPend || w <= mPendIdx)) begin
      selIdx = w; selTgt = tg[w];
    end else if (mPend) begin
      selIdx = mPendIdx; selTgt = mPendTgt;
    end
    if (st) begin
      if (selIdx >= 0) begin
        mPend = 1; mPendIdx = selIdx; mPendTgt = selTgt;
      end
    end else if (selIdx >= 0) begin
      mTaken = 1;
      mPend = 0;
`ifdef PC_MISALIGN_TRAP_EN
      if (selTgt % 4 != 0) begin
        mPc = RV; mMis = 1;
      end else mPc = selTgt;
`else
      mPc = selTgt;
`endif
    end else begin
      mPc = mPc + 32'd4;
    end
  endtask

  task automatic applyStimulus(input string tag, input logic rstN, input logic st, input logic [2:0] vld,
                               input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2);
    reset = rstN;
    stall = st;
    redirectValid = vld;
    redirectTarget = {t2, t1, t0};
    modelStep(rstN, st, vld, t0, t1, t2);
    @(posedge clk);
    #1;
    checkOutput({tag, ".pcOut"}, pcOut, mPc);
    checkOutput({tag, ".pcInc"}, pcIncrementOut, mPc + 32'd4);
    checkOutput({tag, ".pcValid"}, {31'd0, pcValid}, {31'd0, mValid});
    checkOutput({tag, ".taken"}, {31'd0, redirectTaken}, {31'd0, mTaken});
    checkOutput({tag, ".pending"}, {31'd0, redirectPending}, {31'd0, mPend});
    checkOutput({tag, ".misal"}, {31'd0, misalignedOut}, {31'd0, mMis});
  endtask

  initial begin
    logic [2:0] v;
    logic [31:0] r0, r1, r2;
    reset = 1'b0; stall = 1'b0; redirectValid = '0; redirectTarget = '0;
    mPc = RV; mValid = 0; mTaken = 0; mPend = 0; mPendIdx = 0; mPendTgt = 0; mMis = 0;

    // Reset and sequential fetch.
    applyStimulus("rst0", 0, 0, 3'b000, 0, 0, 0);
    applyStimulus("rst1", 0, 1, 3'b111, 32'h40, 32'h44, 32'h48);
    checkOutput("rst.pcValidLow", {31'd0, pcValid}, 32'd0);
    applyStimulus("rel", 1, 0, 3'b010, 0, 32'h500, 0);
    checkOutput("rel.pcHeld", pcOut, 32'h0);
    applyStimulus("seq4", 1, 0, 3'b000, 0, 0, 0);
    applyStimulus("seq8", 1, 0, 3'b000, 0, 0, 0);
    applyStimulus("seqC", 1, 0, 3'b000, 0, 0, 0);
    applyStimulus("seq10", 1, 0, 3'b000, 0, 0, 0);
    checkOutput("seq.pc10", pcOut, 32'h10);

    // Branch beats jump.
    applyStimulus("br", 1, 0, 3'b110, 0, 32'h100, 32'h200);
    checkOutput("br.pc100", pcOut, 32'h100);
    applyStimulus("brNext", 1, 0, 3'b000, 0, 0, 0);
    checkOutput("br.pc104", pcOut, 32'h104);

    // Stalled redirects merge, trap wins on release.
    applyStimulus("st1", 1, 1, 3'b100, 0, 0, 32'h200);
    applyStimulus("st2", 1, 1, 3'b001, 32'h80, 0, 0);
    applyStimulus("st3", 1, 1, 3'b000, 0, 0, 0);
    checkOutput("st.held", pcOut, 32'h104);
    applyStimulus("stRel", 1, 0, 3'b000, 0, 0, 0);
    checkOutput("st.trap", pcOut, 32'h80);
    // Same-index newer request overwrites pending.
    applyStimulus("sameA", 1, 1, 3'b010, 0, 32'h600, 0);
    applyStimulus("sameB", 1, 1, 3'b010, 0, 32'h700, 0);
    applyStimulus("sameRel", 1, 0, 3'b100, 0, 0, 32'h900);

    // Wrap-around.
    applyStimulus("wrapSet", 1, 0, 3'b001, 32'hFFFF_FFFC, 0, 0);
    applyStimulus("wrap", 1, 0, 3'b000, 0, 0, 0);
    checkOutput("wrap.pc0", pcOut, 32'h0);
    checkOutput("wrap.inc4", pcIncrementOut, 32'h4);

    // Reset while stalled with a pending redirect.
    applyStimulus("pend300", 1, 1, 3'b100, 0, 0, 32'h300);
    applyStimulus("rstStall", 0, 1, 3'b000, 0, 0, 0);
    checkOutput("rstStall.pending", {31'd0, redirectPending}, 32'd0);
    applyStimulus("rstRel", 1, 0, 3'b000, 0, 0, 0);
    applyStimulus("rstRun", 1, 0, 3'b000, 0, 0, 0);
    checkOutput("rstRun.no300", pcOut, 32'h4);

    // Misaligned branch target.
    applyStimulus("mis", 1, 0, 3'b010, 0, 32'h102, 0);
`ifdef PC_MISALIGN_TRAP_EN
    checkOutput("mis.trapPc", pcOut, RV);
`else
    checkOutput("mis.verbatim", pcOut, 32'h102);
`endif
    applyStimulus("misAfter", 1, 0, 3'b000, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      v = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
      r0 = $urandom; r1 = $urandom; r2 = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        r0[1:0] = 2'b00; r1[1:0] = 2'b00; r2[1:0] = 2'b00;
      end
      applyStimulus("rand", ($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0), v, r0, r1, r2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
